// File: rtl/stim_sequencer.sv
// -----------------------------------------------------------------------------
// stim_sequencer
//
// Plays a stored list of stimulus words to a consumer over a valid/ready
// handshake. The words are loaded through a simple write port while playback
// is idle.
//
// Optional feature (compile-time macro): STIM_SIGNATURE_EN
//   When this macro is defined, a 32-bit output "sig" is added. It holds a
//   rotate-and-XOR signature of every word the consumer has accepted.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   wr_en       in   load strobe for the stimulus memory
//   wr_addr     in   load address (PC_W bits)
//   wr_data     in   load word; bit DATA_W is the obs flag, lower bits are data
//   start       in   begin playback (sampled once per cycle)
//   stop        in   abort playback
//   loop_en     in   wrap to word 0 after the last word instead of finishing
//   length      in   number of words to play (clamped to DEPTH)
//   stim_ready  in   consumer accepts the current word
//   stim_valid  out  stim_data / stim_obs hold a valid word
//   stim_data   out  data field of the current word
//   stim_obs    out  obs flag of the current word
//   pc          out  index of the current word
//   busy        out  high while playing (state RUN)
//   done        out  one-cycle pulse when playback completes
//   wr_err      out  one-cycle pulse when a load is rejected
//   loop_cnt    out  completed loop passes, saturating at 255
//   sig         out  accepted-word signature (STIM_SIGNATURE_EN only)
// -----------------------------------------------------------------------------
module stim_sequencer #(
  parameter int DATA_W = 31,
  parameter int DEPTH  = 6,
  parameter int PC_W   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PC_W-1:0]   wr_addr,
  input  logic [DATA_W:0]   wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [PC_W-1:0]   length,
  input  logic              stim_ready,
  output logic              stim_valid,
  output logic [DATA_W-1:0] stim_data,
  output logic              stim_obs,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
`ifdef STIM_SIGNATURE_EN
  output logic [31:0]       sig,
`endif
  output logic [7:0]        loop_cnt
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PC_W:0] DEPTH_V = (PC_W+1)'(DEPTH);
  localparam logic [PC_W:0] LEN_ONE = (PC_W+1)'(1);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturating increment for the loop-pass counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Effective play length: the requested length clamped to the memory depth.
  function automatic logic [PC_W:0] clamp_len(input logic [PC_W-1:0] l);
    logic [PC_W:0] lx;
    lx = {1'b0, l};
    return (lx > DEPTH_V) ? DEPTH_V : lx;
  endfunction

`ifdef STIM_SIGNATURE_EN
  // Rotate left by one, then fold in the zero-extended accepted word.
  function automatic logic [31:0] sig_step(input logic [31:0] s,
                                           input logic [DATA_W:0] w);
    return {s[30:0], s[31]} ^ 32'(w);
  endfunction
`endif

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W:0]     len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              werr_q, werr_d;

  logic [DATA_W:0]   mem [0:DEPTH-1];
  logic [DATA_W:0]   rd_word;
  logic [PC_W:0]     len_eff;
  logic              addr_ok;
  logic              running;
  logic              accept;
  logic              last;
  logic              start_ok;

  assign running  = (state_q == ST_RUN);
  assign len_eff  = clamp_len(length);
  assign addr_ok  = ({1'b0, wr_addr} < DEPTH_V);
  assign accept   = running && stim_ready;
  assign last     = ({1'b0, pc_q} == (len_q - LEN_ONE));
  assign start_ok = start && !stop && (len_eff != '0);

  // pc never exceeds L-1 <= DEPTH-1, so the low AW bits address the memory.
  assign rd_word  = mem[pc_q[AW-1:0]];

  // Stimulus memory: no reset, so contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (wr_en && addr_ok && !running)
      mem[wr_addr[AW-1:0]] <= wr_data;
  end

  // Control registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      werr_q  <= werr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    werr_d  = wr_en && (!addr_ok || running);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A zero effective length leaves everything untouched.
        if (start_ok) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          len_d   = len_eff;
        end
      end
      ST_RUN: begin
        // stop has priority over any accept in the same cycle; start is
        // ignored while running.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          if (!last) begin
            pc_d = pc_q + PC_ONE;
          end else if (loop_en) begin
            pc_d  = '0;
            cnt_d = sat_inc8(cnt_q);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef STIM_SIGNATURE_EN
  logic [31:0] sig_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sig_q <= 32'hFFFF_FFFF;
    end else if (!running && start_ok) begin
      sig_q <= 32'hFFFF_FFFF;
    end else if (accept && !stop) begin
      sig_q <= sig_step(sig_q, rd_word);
    end
  end

  assign sig = sig_q;
`endif

  // Outputs decode straight from registered state, so an asserted reset
  // clears them without waiting for a clock edge.
  assign stim_valid = running;
  assign busy       = running;
  assign stim_data  = running ? rd_word[DATA_W-1:0] : '0;
  assign stim_obs   = running ? rd_word[DATA_W] : 1'b0;
  assign pc         = pc_q;
  assign done       = done_q;
  assign wr_err     = werr_q;
  assign loop_cnt   = cnt_q;

endmodule

// File: tb/tb_stim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stim_sequencer
//
// Directed bench for stim_sequencer (default parameters, default build).
// Memory word i holds data 0x100+i with obs = i[0]. A table of per-cycle
// records drives the inputs and lists the outputs expected after each edge;
// reset-related corners are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_stim_sequencer;

  localparam int DATA_W = 31;
  localparam int DEPTH  = 6;
  localparam int PC_W   = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [PC_W-1:0]   wr_addr = '0;
  logic [DATA_W:0]   wr_data = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [PC_W-1:0]   length = '0;
  logic              stim_ready = 1'b0;
  logic              stim_valid;
  logic [DATA_W-1:0] stim_data;
  logic              stim_obs;
  logic [PC_W-1:0]   pc;
  logic              busy;
  logic              done;
  logic              wr_err;
  logic [7:0]        loop_cnt;

  stim_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .length     (length),
    .stim_ready (stim_ready),
    .stim_valid (stim_valid),
    .stim_data  (stim_data),
    .stim_obs   (stim_obs),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err),
    .loop_cnt   (loop_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic            st;
    logic            sp;
    logic            le;
    logic [PC_W-1:0] len;
    logic            rdy;
    logic            wr;
    logic [PC_W-1:0] wa;
    logic [31:0]     wd;
    logic            ev;
    logic [PC_W-1:0] epc;
    logic            ed;
    logic [7:0]      ec;
    logic            ewe;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic le,
                     input int len, input logic rdy, input logic wr,
                     input int wa, input logic [31:0] wd, input logic ev,
                     input int epc, input logic ed, input int ec,
                     input logic ewe);
    vec_t v;
    v.st = st; v.sp = sp; v.le = le; v.len = PC_W'(len); v.rdy = rdy;
    v.wr = wr; v.wa = PC_W'(wa); v.wd = wd;
    v.ev = ev; v.epc = PC_W'(epc); v.ed = ed; v.ec = 8'(ec); v.ewe = ewe;
    tbl.push_back(v);
  endtask

  // Expected data/obs come from the known memory image.
  task automatic chk_word(input string tag, input logic ev,
                          input logic [PC_W-1:0] epc);
    logic [DATA_W-1:0] ed;
    logic              eo;
    ed = ev ? (31'h100 + 31'(epc)) : '0;
    eo = ev ? epc[0] : 1'b0;
    chk({tag, ".data"}, 32'(stim_data), 32'(ed));
    chk({tag, ".obs"},  32'(stim_obs),  32'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst.valid", 32'(stim_valid), 0);
    chk("rst.pc",    32'(pc),         0);
    chk("rst.busy",  32'(busy),       0);
    chk("rst.done",  32'(done),       0);
    chk("rst.werr",  32'(wr_err),     0);
    chk("rst.cnt",   32'(loop_cnt),   0);
    chk("rst.data",  32'(stim_data),  0);
    #10 reset = 1'b1;

    // Load the memory image
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      wr_en   = 1'b1;
      wr_addr = PC_W'(i);
      wr_data = {i[0], 31'h100 + 31'(i)};
      @(posedge clock); #1;
      chk($sformatf("load%0d.werr", i), 32'(wr_err), 0);
    end
    @(negedge clock);
    wr_en = 1'b0;

    // Single pass, ready always high
    add(1,0,0,6,1, 0,0,0, 1,0,0,0,0);
    for (int i = 1; i <= 5; i++) add(0,0,0,6,1, 0,0,0, 1,i,0,0,0);
    add(0,0,0,6,1, 0,0,0, 0,5,1,0,0);
    add(0,0,0,6,0, 0,0,0, 0,5,0,0,0);
    // Backpressure at pc=2 for three cycles
    add(1,0,0,6,0, 0,0,0, 1,0,0,0,0);
    add(0,0,0,6,1, 0,0,0, 1,1,0,0,0);
    add(0,0,0,6,1, 0,0,0, 1,2,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,6,0, 0,0,0, 1,2,0,0,0);
    for (int i = 3; i <= 5; i++) add(0,0,0,6,1, 0,0,0, 1,i,0,0,0);
    add(0,0,0,6,1, 0,0,0, 0,5,1,0,0);
    // Looping with length 3, a start while running, then stop
    add(1,0,1,3,0, 0,0,0, 1,0,0,0,0);
    add(0,0,1,3,1, 0,0,0, 1,1,0,0,0);
    add(0,0,1,3,1, 0,0,0, 1,2,0,0,0);
    add(1,0,1,6,0, 0,0,0, 1,2,0,0,0);
    add(0,0,1,3,1, 0,0,0, 1,0,0,1,0);
    add(0,0,1,3,1, 0,0,0, 1,1,0,1,0);
    add(0,0,1,3,1, 0,0,0, 1,2,0,1,0);
    add(0,0,1,3,1, 0,0,0, 1,0,0,2,0);
    add(0,0,1,3,1, 0,0,0, 1,1,0,2,0);
    add(0,1,1,3,1, 0,0,0, 0,1,0,2,0);
    // Rejected load during RUN, then stop beating accept and start
    add(1,0,0,6,0, 0,0,0, 1,0,0,0,0);
    add(0,0,0,6,1, 0,0,0, 1,1,0,0,0);
    add(0,0,0,6,0, 1,1,32'hDEAD_BEEF, 1,1,0,0,1);
    add(0,0,0,6,0, 0,0,0, 1,1,0,0,0);
    add(1,1,0,6,1, 0,0,0, 0,1,0,0,0);
    // Zero length ignored, out-of-range load, over-long length clamped
    add(1,0,0,0,1, 0,0,0, 0,1,0,0,0);
    add(0,0,0,0,0, 1,6,32'h0, 0,1,0,0,1);
    add(0,0,0,0,0, 0,0,0, 0,1,0,0,0);
    add(1,0,0,9,1, 0,0,0, 1,0,0,0,0);
    for (int i = 1; i <= 5; i++) add(0,0,0,9,1, 0,0,0, 1,i,0,0,0);
    add(0,0,0,9,1, 0,0,0, 0,5,1,0,0);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      @(negedge clock);
      start      = tbl[i].st;
      stop       = tbl[i].sp;
      loop_en    = tbl[i].le;
      length     = tbl[i].len;
      stim_ready = tbl[i].rdy;
      wr_en      = tbl[i].wr;
      wr_addr    = tbl[i].wa;
      wr_data    = tbl[i].wd;
      @(posedge clock); #1;
      chk({tag, ".valid"}, 32'(stim_valid), 32'(tbl[i].ev));
      chk({tag, ".busy"},  32'(busy),       32'(tbl[i].ev));
      chk({tag, ".pc"},    32'(pc),         32'(tbl[i].epc));
      chk({tag, ".done"},  32'(done),       32'(tbl[i].ed));
      chk({tag, ".cnt"},   32'(loop_cnt),   32'(tbl[i].ec));
      chk({tag, ".werr"},  32'(wr_err),     32'(tbl[i].ewe));
      chk_word(tag, tbl[i].ev, tbl[i].epc);
    end

    // Asynchronous reset in the middle of a run
    @(negedge clock);
    start = 1'b1; stop = 1'b0; loop_en = 1'b0; length = 10'd6;
    stim_ready = 1'b1; wr_en = 1'b0;
    @(posedge clock); #1;
    chk("ar.pc0", 32'(pc), 0);
    @(negedge clock);
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("ar.pc2", 32'(pc), 2);
    #2 reset = 1'b0;
    #1;
    chk("ar.valid", 32'(stim_valid), 0);
    chk("ar.pc",    32'(pc),         0);
    chk("ar.busy",  32'(busy),       0);
    chk("ar.data",  32'(stim_data),  0);
    chk("ar.done",  32'(done),       0);
    #3 reset = 1'b1;
    stim_ready = 1'b0;
    @(posedge clock); #1;
    chk("ar.idle", 32'(stim_valid), 0);
    chk("ar.nodone", 32'(done), 0);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    chk("ar.restart.valid", 32'(stim_valid), 1);
    chk_word("ar.w0", 1'b1, 10'd0);
    @(negedge clock);
    start = 1'b0; stim_ready = 1'b1;
    @(posedge clock); #1;
    chk("ar.w1.pc", 32'(pc), 1);
    chk_word("ar.w1", 1'b1, 10'd1);
    @(negedge clock);
    stim_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
